// File: rtl/sfr_load_ctrl_if.sv
// Handshake and SFR-control bundle between a requester and the SFR load controller.
// The master drives the load request; the controller drives the SFR strobes and status.
interface sfr_load_ctrl_if #(
    parameter int SIZE = 32,
    parameter int CW   = 6
);
    logic            start;
    logic            abort;
    logic [SIZE-1:0] din;
    logic [CW-1:0]   nbits;
    logic            sfr_clr;
    logic            sfr_left;
    logic            sfr_incr;
    logic            busy;
    logic            done;

    modport master (
        output start, abort, din, nbits,
        input  sfr_clr, sfr_left, sfr_incr, busy, done
    );

    modport slave (
        input  start, abort, din, nbits,
        output sfr_clr, sfr_left, sfr_incr, busy, done
    );
endinterface

// File: rtl/sfr_load_ctrl.sv
// Moore FSM that loads a pattern into a shift/increment SFR, MSB first:
// clear, then for each bit shift left and, where the bit is 1, increment.
module sfr_load_ctrl #(
    parameter int SIZE = 32,
    parameter int CW   = 6
) (
    input  logic            clk,
    input  logic            clr,
    sfr_load_ctrl_if.slave  bus
);
    localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CW-1:0] NB_MAX  = CW'(SIZE);
    localparam logic [CW-1:0] NB_ONE  = CW'(1);
    localparam logic [CW-1:0] NB_ZERO = CW'(0);
    localparam logic [IW-1:0] IX_ONE  = IW'(1);
    localparam logic [IW-1:0] IX_ZERO = IW'(0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SHIFT = 3'd2,
        ST_INCR  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [SIZE-1:0] din_q, din_d;
    logic [CW-1:0]   nbits_q, nbits_d;
    logic [IW-1:0]   idx_q, idx_d;

    logic sfr_clr_s, sfr_left_s, sfr_incr_s, busy_s, done_s;
    logic in_load_s;

    // State and latched-request registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            din_q   <= {SIZE{1'b0}};
            nbits_q <= NB_ZERO;
            idx_q   <= IX_ZERO;
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
            nbits_q <= nbits_d;
            idx_q   <= idx_d;
        end
    end

    assign in_load_s = (state_q == ST_CLEAR) || (state_q == ST_SHIFT) || (state_q == ST_INCR);

    // Next-state and datapath-register logic
    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        nbits_d = nbits_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_CLEAR;
                    din_d   = bus.din;
                    // Oversized requests saturate to the full SFR width
                    nbits_d = (bus.nbits > NB_MAX) ? NB_MAX : bus.nbits;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (nbits_q == NB_ZERO) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                    idx_d   = IW'(nbits_q - NB_ONE);
                end
            end
            ST_SHIFT: begin
                if (din_q[idx_q]) begin
                    state_d = ST_INCR;
                end else if (idx_q == IX_ZERO) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                    idx_d   = idx_q - IX_ONE;
                end
            end
            ST_INCR: begin
                if (idx_q == IX_ZERO) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                    idx_d   = idx_q - IX_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Cancel wins over every other transition, but only mid-load
        if (bus.abort && in_load_s) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // Output decode from the registered state only
    always_comb begin
        sfr_clr_s  = 1'b0;
        sfr_left_s = 1'b0;
        sfr_incr_s = 1'b0;
        busy_s     = 1'b0;
        done_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_CLEAR: begin
                sfr_clr_s = 1'b1;
                busy_s    = 1'b1;
            end
            ST_SHIFT: begin
                sfr_left_s = 1'b1;
                busy_s     = 1'b1;
            end
            ST_INCR: begin
                sfr_incr_s = 1'b1;
                busy_s     = 1'b1;
            end
            ST_DONE: begin
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    assign bus.sfr_clr  = sfr_clr_s;
    assign bus.sfr_left = sfr_left_s;
    assign bus.sfr_incr = sfr_incr_s;
    assign bus.busy     = busy_s;
    assign bus.done     = done_s;
endmodule
